el2_btb_upd_arb: RTL and testbench

EL2_BTB_UPD_ARB -- requirements
Module: el2_btb_upd_arb

---
 rtl/el2_btb_upd_arb.sv | 193 +++++++++++++++++++
 tb/tb_el2_btb_upd_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_btb_upd_arb.sv
// BTB write-port arbiter (EXU > decode-invalidate FIFO > sweep); outputs registered, 1-cycle grant-to-write.
// No stall paths: decode pushes on a full FIFO without a pop are dropped (sticky dec_ovf); sweep built only with BTB_SWEEP_EN.

module el2_btb_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          full;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign pop     = out_vld && out_rdy;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_rdy  = !full || pop;
  assign push    = in_vld && in_rdy;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end
endmodule

module el2_btb_upd_arb #(
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 22
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exu_upd_valid,
  input  logic [ADDR_W-1:0] exu_upd_index,
  input  logic [TAG_W-1:0]  exu_upd_tag,
  input  logic [DATA_W-1:0] exu_upd_data,
  input  logic              exu_upd_inv,
  input  logic              dec_inv_valid,
  input  logic [ADDR_W-1:0] dec_inv_index,
  input  logic              sweep_start,
  output logic              btb_wr_en,
  output logic [ADDR_W-1:0] btb_wr_index,
  output logic [TAG_W-1:0]  btb_wr_tag,
  output logic [DATA_W-1:0] btb_wr_data,
  output logic              btb_wr_vbit,
  output logic              sweep_busy,
  output logic              sweep_done,
  output logic              dec_ovf
);
  logic              dec_rdy;
  logic              dec_head_vld;
  logic [ADDR_W-1:0] dec_head_index;
  logic              dec_gnt;
  logic              sweep_gnt;
  logic [ADDR_W-1:0] sweep_idx;

  assign dec_gnt = !exu_upd_valid && dec_head_vld;

  el2_btb_upd_fifo #(.DEPTH(2), .W(ADDR_W)) u_dec_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (dec_inv_valid),
    .in_rdy  (dec_rdy),
    .in_dat  (dec_inv_index),
    .out_vld (dec_head_vld),
    .out_rdy (dec_gnt),
    .out_dat (dec_head_index)
  );

  always_ff @(posedge clock) begin
    if (reset)                         dec_ovf <= 1'b0;
    else if (dec_inv_valid && !dec_rdy) dec_ovf <= 1'b1;
  end

`ifdef BTB_SWEEP_EN
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

  sweep_state_t      state;
  logic [ADDR_W-1:0] sweep_cnt;

  assign sweep_gnt = (state == SWEEP) && !exu_upd_valid && !dec_head_vld;
  assign sweep_idx = sweep_cnt;

  // sweep_done is set by the final grant so it lines up with the last write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            sweep_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweep_gnt) begin
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == '1) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end
`else
  logic sweep_unused;
  assign sweep_unused = sweep_start;
  assign sweep_gnt    = 1'b0;
  assign sweep_idx    = '0;
  assign sweep_busy   = 1'b0;
  assign sweep_done   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      btb_wr_en    <= 1'b0;
      btb_wr_index <= '0;
      btb_wr_tag   <= '0;
      btb_wr_data  <= '0;
      btb_wr_vbit  <= 1'b0;
    end else begin
      btb_wr_en <= exu_upd_valid || dec_gnt || sweep_gnt;
      if (exu_upd_valid) begin
        btb_wr_index <= exu_upd_index;
        btb_wr_tag   <= exu_upd_tag;
        btb_wr_data  <= exu_upd_data;
        btb_wr_vbit  <= !exu_upd_inv;
      end else if (dec_gnt) begin
        btb_wr_index <= dec_head_index;
        btb_wr_tag   <= '0;
        btb_wr_data  <= '0;
        btb_wr_vbit  <= 1'b0;
      end else if (sweep_gnt) begin
        btb_wr_index <= sweep_idx;
        btb_wr_tag   <= '0;
        btb_wr_data  <= '0;
        btb_wr_vbit  <= 1'b0;
      end else begin
        btb_wr_index <= '0;
        btb_wr_tag   <= '0;
        btb_wr_data  <= '0;
        btb_wr_vbit  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_el2_btb_upd_arb.sv
// Directed bench for el2_btb_upd_arb: expected writes (with their cycle) are queued at drive time and
// compared by a negedge monitor; sweep scenarios follow BTB_SWEEP_EN.

module tb_el2_btb_upd_arb;
  localparam int AW = 8;
  localparam int TW = 5;
  localparam int DW = 22;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          exu_upd_valid = 1'b0;
  logic [AW-1:0] exu_upd_index = '0;
  logic [TW-1:0] exu_upd_tag = '0;
  logic [DW-1:0] exu_upd_data = '0;
  logic          exu_upd_inv = 1'b0;
  logic          dec_inv_valid = 1'b0;
  logic [AW-1:0] dec_inv_index = '0;
  logic          sweep_start = 1'b0;
  logic          btb_wr_en;
  logic [AW-1:0] btb_wr_index;
  logic [TW-1:0] btb_wr_tag;
  logic [DW-1:0] btb_wr_data;
  logic          btb_wr_vbit;
  logic          sweep_busy;
  logic          sweep_done;
  logic          dec_ovf;

  el2_btb_upd_arb #(.ADDR_W(AW), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .exu_upd_valid (exu_upd_valid),
    .exu_upd_index (exu_upd_index),
    .exu_upd_tag   (exu_upd_tag),
    .exu_upd_data  (exu_upd_data),
    .exu_upd_inv   (exu_upd_inv),
    .dec_inv_valid (dec_inv_valid),
    .dec_inv_index (dec_inv_index),
    .sweep_start   (sweep_start),
    .btb_wr_en     (btb_wr_en),
    .btb_wr_index  (btb_wr_index),
    .btb_wr_tag    (btb_wr_tag),
    .btb_wr_data   (btb_wr_data),
    .btb_wr_vbit   (btb_wr_vbit),
    .sweep_busy    (sweep_busy),
    .sweep_done    (sweep_done),
    .dec_ovf       (dec_ovf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] idx;
    logic [TW-1:0] tag;
    logic [DW-1:0] dat;
    logic          vbit;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_wr(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [DW-1:0] dat,
                        input logic vbit, input logic done, input int c);
    exp_t e;
    e.idx = idx; e.tag = tag; e.dat = dat; e.vbit = vbit; e.done = done; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [AW-1:0] ei, input logic [TW-1:0] et,
                       input logic [DW-1:0] ed, input logic einv, input logic dv, input logic [AW-1:0] di);
    exu_upd_valid = ev; exu_upd_index = ei; exu_upd_tag = et; exu_upd_data = ed; exu_upd_inv = einv;
    dec_inv_valid = dv; dec_inv_index = di;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    sweep_start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clock) begin
    if (btb_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(btb_wr_en), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
        check("wr_index", 32'(btb_wr_index), 32'(mon_e.idx));
        check("wr_tag", 32'(btb_wr_tag), 32'(mon_e.tag));
        check("wr_data", 32'(btb_wr_data), 32'(mon_e.dat));
        check("wr_vbit", 32'(btb_wr_vbit), 32'(mon_e.vbit));
        check("wr_done", 32'(sweep_done), 32'(mon_e.done));
      end
    end else begin
      check("done_without_wr", 32'(sweep_done), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_wr_en", 32'(btb_wr_en), 32'd0);
    check("rst_wr_index", 32'(btb_wr_index), 32'd0);
    check("rst_wr_tag", 32'(btb_wr_tag), 32'd0);
    check("rst_wr_data", 32'(btb_wr_data), 32'd0);
    check("rst_wr_vbit", 32'(btb_wr_vbit), 32'd0);
    check("rst_busy", 32'(sweep_busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_ovf", 32'(dec_ovf), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // EXU write, then nothing the cycle after
    k = cyc;
    drive(1'b1, 8'h3A, 5'h11, 22'h2AAAA, 1'b0, 1'b0, '0);
    exp_wr(8'h3A, 5'h11, 22'h2AAAA, 1'b1, 1'b0, k + 1);
    tick(); idle();
    @(negedge clock);
    tick();
    @(negedge clock);
    check("exu_wr_en_n2", 32'(btb_wr_en), 32'd0);

    // EXU invalidate keeps tag/data, clears vbit
    tick();
    k = cyc;
    drive(1'b1, 8'h44, 5'h03, 22'h12345, 1'b1, 1'b0, '0);
    exp_wr(8'h44, 5'h03, 22'h12345, 1'b0, 1'b0, k + 1);
    tick(); idle();
    drain(10);

    // EXU and decode in the same cycle
    tick();
    k = cyc;
    drive(1'b1, 8'h05, 5'h07, 22'h01111, 1'b0, 1'b1, 8'h06);
    exp_wr(8'h05, 5'h07, 22'h01111, 1'b1, 1'b0, k + 1);
    exp_wr(8'h06, '0, '0, 1'b0, 1'b0, k + 2);
    tick(); idle();
    drain(10);

    // Lone decode: two-cycle latency
    tick();
    k = cyc;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h20);
    exp_wr(8'h20, '0, '0, 1'b0, 1'b0, k + 2);
    tick(); idle();
    drain(10);

    // Full FIFO with a simultaneous pop accepts the push
    tick();
    k = cyc;
    drive(1'b1, 8'h01, 5'h01, 22'h00101, 1'b0, 1'b1, 8'h50);
    exp_wr(8'h01, 5'h01, 22'h00101, 1'b1, 1'b0, k + 1);
    tick();
    drive(1'b1, 8'h02, 5'h02, 22'h00202, 1'b0, 1'b1, 8'h51);
    exp_wr(8'h02, 5'h02, 22'h00202, 1'b1, 1'b0, k + 2);
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 8'h52);
    exp_wr(8'h50, '0, '0, 1'b0, 1'b0, k + 3);
    exp_wr(8'h51, '0, '0, 1'b0, 1'b0, k + 4);
    exp_wr(8'h52, '0, '0, 1'b0, 1'b0, k + 5);
    tick(); idle();
    @(negedge clock);
    check("ovf_full_with_pop", 32'(dec_ovf), 32'd0);
    drain(10);

    // Overflow: third decode push dropped while EXU holds the port
    tick();
    k = cyc;
    drive(1'b1, 8'h30, 5'h10, 22'h03000, 1'b0, 1'b1, 8'h10);
    exp_wr(8'h30, 5'h10, 22'h03000, 1'b1, 1'b0, k + 1);
    tick();
    drive(1'b1, 8'h31, 5'h11, 22'h03100, 1'b0, 1'b1, 8'h11);
    exp_wr(8'h31, 5'h11, 22'h03100, 1'b1, 1'b0, k + 2);
    tick();
    drive(1'b1, 8'h32, 5'h12, 22'h03200, 1'b1, 1'b1, 8'h12);
    exp_wr(8'h32, 5'h12, 22'h03200, 1'b0, 1'b0, k + 3);
    @(negedge clock);
    check("ovf_before_drop", 32'(dec_ovf), 32'd0);
    tick();
    drive(1'b1, 8'h33, 5'h13, 22'h03300, 1'b0, 1'b0, '0);
    exp_wr(8'h33, 5'h13, 22'h03300, 1'b1, 1'b0, k + 4);
    exp_wr(8'h10, '0, '0, 1'b0, 1'b0, k + 5);
    exp_wr(8'h11, '0, '0, 1'b0, 1'b0, k + 6);
    @(negedge clock);
    check("ovf_after_drop", 32'(dec_ovf), 32'd1);
    tick(); idle();
    drain(12);
    repeat (3) tick();
    check("ovf_sticky", 32'(dec_ovf), 32'd1);

    // Reset flushes a queued decode and clears dec_ovf
    k = cyc;
    drive(1'b1, 8'h60, 5'h06, 22'h06000, 1'b0, 1'b1, 8'h70);
    exp_wr(8'h60, 5'h06, 22'h06000, 1'b1, 1'b0, k + 1);
    tick(); idle();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rst2_wr_en", 32'(btb_wr_en), 32'd0);
    check("rst2_ovf", 32'(dec_ovf), 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("rst2_flushed", 32'(sb.size()), 32'd0);
    tick();

`ifdef BTB_SWEEP_EN
    // Full sweep with no other traffic
    k = cyc;
    sweep_start = 1'b1;
    for (int i = 0; i < 256; i++) exp_wr(AW'(i), '0, '0, 1'b0, i == 255, k + 2 + i);
    tick(); idle();
    @(negedge clock);
    check("sweep_busy_start", 32'(sweep_busy), 32'd1);
    drain(300);
    @(negedge clock);
    check("sweep_busy_end", 32'(sweep_busy), 32'd0);
    tick();

    // EXU write at counter 10 stalls the sweep; restart request mid-sweep ignored
    k = cyc;
    sweep_start = 1'b1;
    for (int i = 0; i < 10; i++) exp_wr(AW'(i), '0, '0, 1'b0, 1'b0, k + 2 + i);
    exp_wr(8'h80, 5'h0A, 22'h3FFFF, 1'b1, 1'b0, k + 12);
    for (int i = 10; i < 256; i++) exp_wr(AW'(i), '0, '0, 1'b0, i == 255, k + 3 + i);
    tick(); idle();
    repeat (10) tick();
    drive(1'b1, 8'h80, 5'h0A, 22'h3FFFF, 1'b0, 1'b0, '0);
    tick(); idle();
    repeat (38) tick();
    sweep_start = 1'b1;
    tick(); idle();
    drain(300);
    @(negedge clock);
    check("sweep2_busy_end", 32'(sweep_busy), 32'd0);
    tick();

    // Reset at counter 100 aborts the sweep
    k = cyc;
    sweep_start = 1'b1;
    for (int i = 0; i < 100; i++) exp_wr(AW'(i), '0, '0, 1'b0, 1'b0, k + 2 + i);
    tick(); idle();
    repeat (100) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("abort_wr_en", 32'(btb_wr_en), 32'd0);
    check("abort_busy", 32'(sweep_busy), 32'd0);
    check("abort_done", 32'(sweep_done), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("abort_busy_after", 32'(sweep_busy), 32'd0);
    end
    check("abort_pending", 32'(sb.size()), 32'd0);
`else
    // Sweep not built: start pulse must do nothing
    sweep_start = 1'b1;
    tick(); idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("nosweep_busy", 32'(sweep_busy), 32'd0);
      check("nosweep_wr_en", 32'(btb_wr_en), 32'd0);
    end
`endif

    tick();
    check("final_pending", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
